dac_tx_scheduler: RTL and testbench

- Sequences and shares the 14-bit DAC sample path between two sample sources: ch0, the 2FSK modem, and ch1, the calibration/test tone.
- Grants the path to one source per burst, with round-robin fairness.
- Inserts guard intervals of idle code before and after each burst.
- Enforces a maximum burst length.
- Drives data_send into the AD9767 output formatter every clk_sample cycle.

---
 rtl/dac_tx_scheduler.sv | 144 ++++++++++++++
 tb/tb_dac_tx_scheduler.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/dac_tx_scheduler.sv
// Two-source burst scheduler for the 14-bit DAC path: round-robin grant,
// idle-code guard intervals around each burst and a hard burst-length cap.
module dac_tx_scheduler #(
  parameter int                       DATA_W    = 14,
  parameter int                       GUARD_LEN = 16,
  parameter int                       MAX_BURST = 4096,
  parameter logic signed [DATA_W-1:0] IDLE_CODE = '0
) (
  input  logic                     clk_sample,
  input  logic                     rst_n,
  input  logic                     enable,
  input  logic                     req0,
  input  logic signed [DATA_W-1:0] din0,
  input  logic                     last0,
  input  logic                     req1,
  input  logic signed [DATA_W-1:0] din1,
  input  logic                     last1,
  output logic                     grant0,
  output logic                     grant1,
  output logic signed [DATA_W-1:0] data_send,
  output logic                     tx_active,
  output logic                     owner,
  output logic                     burst_done,
  output logic                     burst_abort
);

  typedef enum logic [1:0] {S_IDLE, S_GUARD_PRE, S_ACTIVE, S_GUARD_POST} state_t;

  localparam logic [7:0]  GUARD_LAST = 8'(GUARD_LEN - 1);
  localparam logic [15:0] BURST_LAST = 16'(MAX_BURST - 1);

  state_t                   state_q, state_d;
  logic [7:0]               guard_cnt_q, guard_cnt_d;
  logic [15:0]              burst_cnt_q, burst_cnt_d;
  logic                     rr_q, rr_d;
  logic                     owner_q, owner_d;
  logic                     grant0_q, grant0_d;
  logic                     grant1_q, grant1_d;
  logic signed [DATA_W-1:0] data_send_q, data_send_d;
  logic                     tx_active_q, tx_active_d;
  logic                     burst_done_q, burst_done_d;
  logic                     burst_abort_q, burst_abort_d;

  logic                     own_req, own_last, stop, guard_end, burst_end, winner;
  logic signed [DATA_W-1:0] own_din;

  // Only the latched owner's inputs are ever looked at once a burst is underway.
  always_comb begin
    own_req   = owner_q ? req1  : req0;
    own_last  = owner_q ? last1 : last0;
    own_din   = owner_q ? din1  : din0;
    stop      = !own_req || !enable;
    guard_end = (guard_cnt_q == GUARD_LAST);
    burst_end = (burst_cnt_q == BURST_LAST);
    winner    = req1 && (!req0 || rr_q);
  end

  always_ff @(posedge clk_sample or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:       if (enable && (req0 || req1)) state_d = S_GUARD_PRE;
      S_GUARD_PRE:  if (stop) state_d = S_GUARD_POST;
                    else if (guard_end) state_d = S_ACTIVE;
      S_ACTIVE:     if (stop || own_last || burst_end) state_d = S_GUARD_POST;
      S_GUARD_POST: if (guard_end) state_d = S_IDLE;
      default:      state_d = S_IDLE;
    endcase
  end

  always_comb begin
    owner_d       = owner_q;
    rr_d          = rr_q;
    burst_cnt_d   = burst_cnt_q;
    data_send_d   = IDLE_CODE;
    tx_active_d   = 1'b0;
    burst_done_d  = 1'b0;
    burst_abort_d = 1'b0;

    guard_cnt_d = (state_d == state_q &&
                   (state_q == S_GUARD_PRE || state_q == S_GUARD_POST))
                  ? guard_cnt_q + 8'd1 : 8'd0;

    if (state_q == S_IDLE && state_d == S_GUARD_PRE) begin
      owner_d     = winner;
      burst_cnt_d = 16'd0;
    end

    if (state_q == S_ACTIVE && !stop) begin
      data_send_d = own_din;
      tx_active_d = 1'b1;
      burst_cnt_d = burst_cnt_q + 16'd1;
    end

    // Leaving a burst: last wins over truncation, any stop overrides both.
    if (state_d == S_GUARD_POST && state_q != S_GUARD_POST) begin
      rr_d          = ~owner_q;
      burst_done_d  = (state_q == S_ACTIVE) && !stop && own_last;
      burst_abort_d = (state_q == S_GUARD_PRE) || stop || !own_last;
    end

    grant0_d = (state_d == S_ACTIVE) && !owner_d;
    grant1_d = (state_d == S_ACTIVE) &&  owner_d;
  end

  always_ff @(posedge clk_sample or negedge rst_n) begin
    if (!rst_n) begin
      guard_cnt_q   <= '0;
      burst_cnt_q   <= '0;
      rr_q          <= 1'b0;
      owner_q       <= 1'b0;
      grant0_q      <= 1'b0;
      grant1_q      <= 1'b0;
      data_send_q   <= IDLE_CODE;
      tx_active_q   <= 1'b0;
      burst_done_q  <= 1'b0;
      burst_abort_q <= 1'b0;
    end else begin
      guard_cnt_q   <= guard_cnt_d;
      burst_cnt_q   <= burst_cnt_d;
      rr_q          <= rr_d;
      owner_q       <= owner_d;
      grant0_q      <= grant0_d;
      grant1_q      <= grant1_d;
      data_send_q   <= data_send_d;
      tx_active_q   <= tx_active_d;
      burst_done_q  <= burst_done_d;
      burst_abort_q <= burst_abort_d;
    end
  end

  assign grant0      = grant0_q;
  assign grant1      = grant1_q;
  assign data_send   = data_send_q;
  assign tx_active   = tx_active_q;
  assign owner       = owner_q;
  assign burst_done  = burst_done_q;
  assign burst_abort = burst_abort_q;

endmodule

// File: tb/tb_dac_tx_scheduler.sv
// Directed bench for dac_tx_scheduler with GUARD_LEN=4, MAX_BURST=8; expected
// sequences are hand-derived cycle by cycle.
module tb_dac_tx_scheduler;

  logic               clk_sample = 1'b0;
  logic               rst_n = 1'b0;
  logic               enable = 1'b0;
  logic               req0 = 1'b0, last0 = 1'b0;
  logic               req1 = 1'b0, last1 = 1'b0;
  logic signed [13:0] din0 = '0, din1 = '0;
  logic               grant0, grant1, tx_active, owner, burst_done, burst_abort;
  logic signed [13:0] data_send;

  int n_checks = 0;
  int n_fail   = 0;

  int nb, n_abort, n_done, run_len, idle_run, min_gap, cur_own;
  logic seen_tx, prev_g, prev_tx;

  dac_tx_scheduler #(
    .DATA_W(14), .GUARD_LEN(4), .MAX_BURST(8), .IDLE_CODE(14'sd0)
  ) dut (
    .clk_sample(clk_sample), .rst_n(rst_n), .enable(enable),
    .req0(req0), .din0(din0), .last0(last0),
    .req1(req1), .din1(din1), .last1(last1),
    .grant0(grant0), .grant1(grant1), .data_send(data_send),
    .tx_active(tx_active), .owner(owner),
    .burst_done(burst_done), .burst_abort(burst_abort)
  );

  always #5 clk_sample = ~clk_sample;

  task automatic check_eq(input string tag, input logic signed [31:0] got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_sample);
    #1;
  endtask

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    // Reset state
    step(); step();
    check_eq("rst_grant0", grant0, 0);
    check_eq("rst_grant1", grant1, 0);
    check_eq("rst_data", data_send, 0);
    check_eq("rst_tx", tx_active, 0);
    check_eq("rst_owner", owner, 0);
    check_eq("rst_done", burst_done, 0);
    check_eq("rst_abort", burst_abort, 0);
    rst_n = 1'b1;
    step();

    // Single ch0 burst, samples 100..104 with last on the 5th
    enable = 1'b1; req0 = 1'b1; din1 = -14'sd1; last1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check_eq("t1_pre_grant", grant0, 0);
      check_eq("t1_pre_data", data_send, 0);
    end
    check_eq("t1_owner", owner, 0);
    step();
    check_eq("t1_grant_rise", grant0, 1);
    check_eq("t1_grant1_low", grant1, 0);
    check_eq("t1_tx_before", tx_active, 0);
    for (int i = 0; i < 5; i++) begin
      din0 = 14'(100 + i); last0 = (i == 4);
      step();
      check_eq("t1_data", data_send, 100 + i);
      check_eq("t1_tx", tx_active, 1);
      check_eq("t1_grant", grant0, (i < 4) ? 1 : 0);
      check_eq("t1_done", burst_done, (i == 4) ? 1 : 0);
      check_eq("t1_abort", burst_abort, 0);
    end
    req0 = 1'b0; last0 = 1'b0; din0 = '0; last1 = 1'b0;
    step();
    check_eq("t1_tx_end", tx_active, 0);
    check_eq("t1_data_end", data_send, 0);
    check_eq("t1_done_end", burst_done, 0);
    idle_steps(6);

    // Truncation on ch1; ch0's last is held high and must be ignored
    req1 = 1'b1; last0 = 1'b1;
    step();
    check_eq("tr_owner", owner, 1);
    idle_steps(3);
    step();
    check_eq("tr_grant_rise", grant1, 1);
    check_eq("tr_grant0_low", grant0, 0);
    for (int i = 0; i < 8; i++) begin
      din1 = 14'(-5 * (i + 1));
      step();
      check_eq("tr_data", data_send, -5 * (i + 1));
      check_eq("tr_tx", tx_active, 1);
      check_eq("tr_grant", grant1, (i < 7) ? 1 : 0);
      check_eq("tr_abort", burst_abort, (i == 7) ? 1 : 0);
      check_eq("tr_done", burst_done, 0);
    end
    req1 = 1'b0; last0 = 1'b0; din1 = '0;
    step();
    check_eq("tr_tx_end", tx_active, 0);
    check_eq("tr_abort_end", burst_abort, 0);
    idle_steps(6);

    // Abort: req0 drops on the 3rd ACTIVE cycle together with last0
    req0 = 1'b1;
    idle_steps(4);
    step();
    check_eq("ab_grant_rise", grant0, 1);
    din0 = 14'sd200; step();
    check_eq("ab_data0", data_send, 200);
    din0 = 14'sd201; step();
    check_eq("ab_data1", data_send, 201);
    din0 = 14'sd202; req0 = 1'b0; last0 = 1'b1;
    step();
    check_eq("ab_data_idle", data_send, 0);
    check_eq("ab_tx", tx_active, 0);
    check_eq("ab_abort", burst_abort, 1);
    check_eq("ab_done", burst_done, 0);
    check_eq("ab_grant", grant0, 0);
    last0 = 1'b0;
    step();
    check_eq("ab_abort_end", burst_abort, 0);
    idle_steps(6);

    // Enable low in IDLE with req0 high: never granted
    enable = 1'b0; req0 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      check_eq("en_idle_grant", grant0, 0);
      check_eq("en_idle_tx", tx_active, 0);
    end

    // Enable falls during GUARD_PRE
    enable = 1'b1;
    step(); step();
    enable = 1'b0;
    step();
    check_eq("en_pre_abort", burst_abort, 1);
    check_eq("en_pre_grant", grant0, 0);
    for (int i = 0; i < 8; i++) begin
      step();
      check_eq("en_post_grant", grant0, 0);
      check_eq("en_post_abort", burst_abort, 0);
    end
    req0 = 1'b0;
    idle_steps(2);

    // Reset mid-burst on ch1
    enable = 1'b1; req1 = 1'b1; din1 = 14'sd7;
    idle_steps(4);
    step();
    check_eq("rb_grant_rise", grant1, 1);
    step();
    check_eq("rb_tx", tx_active, 1);
    check_eq("rb_data", data_send, 7);
    #2 rst_n = 1'b0;
    #1;
    check_eq("rb_grant1", grant1, 0);
    check_eq("rb_grant0", grant0, 0);
    check_eq("rb_data0", data_send, 0);
    check_eq("rb_tx0", tx_active, 0);
    check_eq("rb_owner", owner, 0);
    req0 = 1'b1; din0 = 14'sd11; din1 = -14'sd22;
    step();
    rst_n = 1'b1;

    // Round-robin with both requests held: ch0, ch1, ch0, each truncated at 8
    nb = 0; n_abort = 0; n_done = 0; run_len = 0; idle_run = 0;
    min_gap = 1000; cur_own = -1; seen_tx = 1'b0; prev_g = 1'b0; prev_tx = 1'b0;
    for (int c = 0; c < 50; c++) begin
      step();
      if (grant0 && grant1) check_eq("rr_both_grant", 1, 0);
      if ((grant0 || grant1) && !prev_g) begin
        check_eq("rr_order", grant1, (nb % 2));
        check_eq("rr_owner", owner, (nb % 2));
        cur_own = grant1 ? 1 : 0;
        nb++;
      end
      if (tx_active) begin
        check_eq("rr_data", data_send, (cur_own == 1) ? -22 : 11);
        if (seen_tx && !prev_tx && idle_run < min_gap) min_gap = idle_run;
        seen_tx = 1'b1; idle_run = 0; run_len++;
      end else begin
        if (prev_tx) begin
          check_eq("rr_burst_len", run_len, 8);
          run_len = 0;
        end
        idle_run++;
      end
      if (burst_abort) n_abort++;
      if (burst_done) n_done++;
      prev_g = grant0 || grant1;
      prev_tx = tx_active;
    end
    check_eq("rr_bursts", nb, 3);
    check_eq("rr_aborts", n_abort, 3);
    check_eq("rr_dones", n_done, 0);
    check_eq("rr_min_gap", min_gap, 9);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
